// File: rtl/outbuf_stream_pkg.sv
// Shared types and header layout for the output-buffer AXI-Stream drain stage.
// The optional header beat (OUTBUF_STREAM_HDR_EN) is built with make_header.
package outbuf_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] HDR_PAD   = 8'h00;
  localparam int         HDR_CNT_W = 16;
  localparam int         HDR_W     = 32;

  // Header word: {magic, pad, word count}
  function automatic logic [HDR_W-1:0] make_header(input logic [HDR_CNT_W-1:0] cnt);
    return {HDR_MAGIC, HDR_PAD, cnt};
  endfunction

endpackage

// File: rtl/outbuf_stream_fifo.sv
// Synchronous beat FIFO with occupancy output; head word is visible on rd_data
// without a read strobe (show-ahead), so it can drive TDATA directly.
module outbuf_stream_fifo
  import outbuf_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign occupancy = occ_q;
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/outbuf_axis_streamer.sv
// Drains a word range of the output buffer (registered read port) into an
// AXI-Stream master. Optional header beat: define OUTBUF_STREAM_HDR_EN.
module outbuf_axis_streamer
  import outbuf_stream_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int AXIS_DWIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     end_addr,
  output logic                    buf_req,
  output logic [ADDR_WIDTH-1:0]   buf_addr,
  input  logic [AXIS_DWIDTH-1:0]  buf_data,
  output logic [AXIS_DWIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     beat_count
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH:0]    end_lat;
  logic [ADDR_WIDTH:0]    cnt_q;
  logic                   vld_p1, last_p1;

  logic                   start_acc, empty_rng, credit_ok, issue, is_last_rd, pop;
  logic                   fifo_wr, fifo_empty;
  logic [AXIS_DWIDTH:0]   fifo_wdata, fifo_rdata;
  logic [OCC_W-1:0]       occ;

  assign start_acc  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign empty_rng  = (end_addr <= {1'b0, start_addr});
  // Credit counts the read still in the buffer pipeline; a same-cycle pop earns nothing
  assign credit_ok  = ({1'b0, occ} + {{OCC_W{1'b0}}, vld_p1}) < (OCC_W+1)'(FIFO_DEPTH);
  assign issue      = (state == ST_FETCH) && credit_ok;
  assign is_last_rd = (({1'b0, addr_q} + (ADDR_WIDTH+1)'(1)) == end_lat);
  assign pop        = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
`ifdef OUTBUF_STREAM_HDR_EN
          state_nxt = empty_rng ? ST_FLUSH : ST_FETCH;
`else
          state_nxt = empty_rng ? ST_DONE : ST_FETCH;
`endif
        end
      end
      ST_FETCH: begin
        if (issue && is_last_rd) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave as the final beat is accepted so done lands the cycle after it
        if (!vld_p1 && (fifo_empty || ((occ == OCC_W'(1)) && pop))) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      end_lat <= '0;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= issue;
      last_p1 <= issue && is_last_rd;
      if (start_acc) begin
        addr_q  <= start_addr;
        end_lat <= end_addr;
      end else if (issue && !is_last_rd) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
      end
      if (start_acc)  cnt_q <= '0;
      else if (pop)   cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
    end
  end

  // p1 -> FIFO: buffer dout is valid the cycle after the read address
`ifdef OUTBUF_STREAM_HDR_EN
  logic [HDR_CNT_W-1:0] hdr_cnt;
  assign hdr_cnt    = empty_rng ? '0 : HDR_CNT_W'(end_addr - {1'b0, start_addr});
  assign fifo_wr    = vld_p1 || start_acc;
  assign fifo_wdata = start_acc ? {empty_rng, AXIS_DWIDTH'(make_header(hdr_cnt))}
                                : {last_p1, buf_data};
`else
  assign fifo_wr    = vld_p1;
  assign fifo_wdata = {last_p1, buf_data};
`endif

  outbuf_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXIS_DWIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (fifo_wr),
    .wr_data   (fifo_wdata),
    .rd_en     (pop),
    .rd_data   (fifo_rdata),
    .occupancy (occ),
    .empty     (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[AXIS_DWIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_rdata[AXIS_DWIDTH];
  assign busy          = (state == ST_FETCH) || (state == ST_FLUSH);
  assign done          = (state == ST_DONE);
  assign buf_req       = (state == ST_FETCH) || ((state == ST_FLUSH) && vld_p1);
  assign buf_addr      = addr_q;
  assign beat_count    = cnt_q;

endmodule

// File: tb/tb_outbuf_axis_streamer.sv
// Directed bench for outbuf_axis_streamer with a registered-read buffer model
// and an AXI-Stream sink that records every accepted beat.
module tb_outbuf_axis_streamer;

  logic        clk = 1'b0;
  logic        rst_n, start, tready;
  logic [14:0] start_addr, buf_addr;
  logic [15:0] end_addr, beat_count;
  logic [31:0] buf_data, tdata;
  logic        buf_req, tvalid, tlast, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int rdy_mode = 0;
  int viol_excl = 0;
  int viol_stab = 0;
  int done_cyc;
  logic [14:0] max_addr;

  logic [31:0] q_data[$];
  bit          q_last[$];
  int          q_cyc[$];

  bit          prev_stall = 0;
  logic [31:0] prev_data;
  bit          prev_last;

  outbuf_axis_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .buf_req       (buf_req),
    .buf_addr      (buf_addr),
    .buf_data      (buf_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .done          (done),
    .beat_count    (beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [14:0] a);
    if (a < 15'd4) return (32'(a) + 32'd1) * 32'h11;
    return 32'hD000_0000 | 32'(a);
  endfunction

  // Buffer model: one-cycle registered read
  always @(posedge clk) buf_data <= word(buf_addr);
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) tready = 1'b1;
    else begin
      int k;
      k = cyc - t0;
      tready = (k >= 5 && k < 15) ? 1'b0 : k[0];
    end
  end

  // Sink monitor: a beat seen here transfers on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (done && busy) viol_excl++;
      if (busy && buf_addr > max_addr) max_addr = buf_addr;
      if (prev_stall && (!tvalid || tdata != prev_data || tlast != prev_last)) viol_stab++;
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
        q_cyc.push_back(cyc - t0 + 1);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [14:0] sa, input logic [15:0] ea);
    q_data.delete(); q_last.delete(); q_cyc.delete();
    max_addr = '0;
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    done_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        done_cyc = cyc - t0 + 1;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic check_beats(input string tag, input logic [14:0] sa, input int n, input bit chk_cyc);
    int idx;
    int hdr;
    hdr = 0;
`ifdef OUTBUF_STREAM_HDR_EN
    hdr = 1;
    if (q_data.size() > 0) begin
      chk({tag, "_hdr"}, q_data[0], {8'hA5, 8'h00, 16'(n)});
      chk({tag, "_hdr_last"}, q_last[0], (n == 0));
      if (chk_cyc) chk({tag, "_hdr_cyc"}, q_cyc[0], 1);
    end
`endif
    chk({tag, "_nbeats"}, q_data.size(), n + hdr);
    for (int i = 0; i < n; i++) begin
      idx = i + hdr;
      if (idx < q_data.size()) begin
        chk({tag, "_data"}, q_data[idx], word(sa + 15'(i)));
        chk({tag, "_last"}, q_last[idx], (i == n - 1));
        if (chk_cyc) chk({tag, "_cyc"}, q_cyc[idx], 3 + i);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_buf_req"}, buf_req, 0);
    chk({tag, "_buf_addr"}, buf_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
  endtask

  initial begin
    int hdr;
    bit got3;
    hdr = 0;
`ifdef OUTBUF_STREAM_HDR_EN
    hdr = 1;
`endif
    rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic 4-word transfer at full rate
    do_start(15'd0, 16'd4);
    chk("t1_busy_c1", busy, 1);
    chk("t1_addr_c1", buf_addr, 0);
    chk("t1_req_c1", buf_req, 1);
    wait_done("t1", 100);
    chk("t1_done_cyc", done_cyc, 7);
    check_beats("t1", 15'd0, 4, 1);
    chk("t1_beat_count", beat_count, 4 + hdr);

    // Top of the address space, no wrap
    do_start(15'h7FFE, 16'h8000);
    chk("t2_addr_c1", buf_addr, 15'h7FFE);
    wait_done("t2", 100);
    chk("t2_done_cyc", done_cyc, 5);
    check_beats("t2", 15'h7FFE, 2, 1);
    chk("t2_max_addr", max_addr, 15'h7FFF);

    // 16 words under toggling backpressure and a long stall
    rdy_mode = 1;
    do_start(15'h100, 16'h110);
    wait_done("t3", 300);
    check_beats("t3", 15'h100, 16, 0);
    chk("t3_beat_count", beat_count, 16 + hdr);
    chk("t3_stable", viol_stab, 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Empty range
    do_start(15'd5, 16'd5);
    wait_done("t4", 20);
    chk("t4_done_cyc", done_cyc, 1 + hdr);
    check_beats("t4", 15'd5, 0, 1);
    chk("t4_beat_count", beat_count, hdr);

    // Reset in the middle of an 8-word transfer
    do_start(15'h20, 16'h28);
    got3 = 0;
    for (int i = 0; i < 50 && !got3; i++) begin
      @(negedge clk);
      if (q_data.size() >= 3 + hdr) got3 = 1;
    end
    chk("t5_three_beats", got3, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(15'd0, 16'd2);
    wait_done("t5", 100);
    chk("t5_done_cyc", done_cyc, 5);
    check_beats("t5", 15'd0, 2, 1);
    chk("t5_beat_count", beat_count, 2 + hdr);

    // Second start during FETCH is ignored
    do_start(15'h40, 16'h44);
    @(posedge clk);
    #1;
    start_addr = 15'h50; end_addr = 16'h60; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t6", 100);
    chk("t6_done_cyc", done_cyc, 7);
    check_beats("t6", 15'h40, 4, 1);
    chk("t6_beat_count", beat_count, 4 + hdr);
    chk("t6_addr_end", buf_addr, 15'h43);

    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);
    chk("done_busy_excl", viol_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/outbuf_axis_streamer.md
# outbuf_axis_streamer

Downstream drain stage for the Sobel userlogic output buffer. After userlogic reports completion, it walks a word range of the output buffer through the buffer's registered read port. It emits each word as one AXI-Stream beat, with full backpressure support and TLAST on the final beat. It owns the output-buffer address only while busy; the top-level mux gives `buf_req` priority over the host read address and below userlogic write enables.

## Interface
Parameters:
- `ADDR_WIDTH`, 15: output-buffer word-address width.
- `AXIS_DWIDTH`, 32: buffer word and TDATA width.
- `FIFO_DEPTH`, 4: internal beat FIFO entries (power of two, ≥4).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; sampled only in IDLE or DONE.
- `start_addr` in ADDR_WIDTH: first word address (inclusive).
- `end_addr` in ADDR_WIDTH+1: last word address + 1 (exclusive); up to 2^ADDR_WIDTH.
- `buf_req` out 1: requests the output-buffer address mux.
- `buf_addr` out ADDR_WIDTH: registered read address.
- `buf_data` in AXIS_DWIDTH: buffer dout; valid one cycle after `buf_addr` is presented.
- `m_axis_tdata` out AXIS_DWIDTH: beat data.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: sink ready.
- `m_axis_tlast` out 1: final beat of transfer.
- `busy` out 1: transfer in progress.
- `done` out 1: level; transfer complete; held until next accepted `start`.
- `beat_count` out ADDR_WIDTH+1: beats accepted by sink in current/last transfer.

## Operation
- States: IDLE, FETCH, FLUSH, DONE.
- IDLE/DONE + `start`:
  - Latch `start_addr`/`end_addr`; clear `beat_count` and `done`.
  - Go to FETCH.
  - If `end_addr <= start_addr` (empty range), go directly to DONE the next cycle with no beats.
- FETCH:
  - Each cycle, issue one read if (FIFO occupancy + reads in flight) < FIFO_DEPTH. In-flight count ≤ 2; no credit is taken for a same-cycle pop.
  - `buf_addr` increments by 1 per issued read.
  - After the read of `end_addr-1` is issued, go to FLUSH.
- FLUSH: wait until in-flight = 0, FIFO empty, and last beat accepted; then go to DONE.
- Returned data is written into the FIFO two cycles after the issue decision. FIFO head drives `m_axis_tdata`.
- Beat transfer occurs on `tvalid && tready`; `beat_count` increments on each transfer.
- `m_axis_tlast` = 1 exactly on the beat carrying word `end_addr-1`.
- `start` while in FETCH/FLUSH is ignored.
- `buf_req` = 1 in FETCH and FLUSH while in-flight ≠ 0; otherwise 0.
- Address arithmetic: `buf_addr` is ADDR_WIDTH bits. `end_addr` = 2^ADDR_WIDTH terminates after address 2^ADDR_WIDTH−1; no wrap occurs.

## Timing
- Reset values: state IDLE; `buf_req`=0, `buf_addr`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `beat_count`=0; FIFO empty; in-flight=0.
- Reset mid-transfer aborts immediately. No partial beat is held; the next `start` begins fresh.
- `start` sampled at edge 0:
  - `busy`=1 and `buf_addr`=`start_addr` in cycle 1.
  - Data arrives in cycle 2.
  - `m_axis_tvalid`=1 in cycle 3.
- With `tready` held high, the block sustains 1 beat/cycle. An N-word transfer has its last beat in cycle N+2; `done`=1 and `busy`=0 in cycle N+3.
- While `tvalid && !tready`, `tdata` and `tlast` are held stable; `tvalid` never drops without a transfer.
- `done` and `busy` are never high together.

## Configuration
- `OUTBUF_STREAM_HDR_EN` defined:
  - Prepend one header beat {8'hA5, 8'h00, 16-bit word count} before the data beats.
  - Header is emitted in cycle 1 after `start`. `beat_count` includes it.
  - Empty range emits the header alone with `tlast`=1.
- Not defined: no header; empty range emits no beats.

## Structure
- Package `outbuf_stream_pkg`: state enum typedef, header magic constant 8'hA5, header layout constant.
- Sub-module `outbuf_stream_fifo`: synchronous FIFO_DEPTH×AXIS_DWIDTH with occupancy output, used as the beat FIFO.

## Test plan
- start_addr=0, end_addr=4, words 0x11..0x44, tready=1 -> four beats in cycles 3–6, tlast on 0x44, `done` in cycle 7, `beat_count`=4.
- start_addr=0x7FFE, end_addr=0x8000 -> beats from 0x7FFE and 0x7FFF only; `buf_addr` never exceeds 0x7FFF.
- 16-word transfer, tready toggling 1/0 every cycle plus a 10-cycle stall -> all 16 words in order, no loss or duplication, tdata stable during stalls, in-flight never exceeds FIFO_DEPTH.
- start_addr=5, end_addr=5 -> no beats (header-only beat with `OUTBUF_STREAM_HDR_EN`), `done` in cycle 1, `beat_count`=0 (1 with header).
- rst_n low after 3 of 8 beats, then new start 0..2 -> outputs return to reset values; new transfer emits exactly 2 beats.
- Second start pulse during FETCH -> ignored; latched range unchanged.
